// File: rtl/uart_tx_arb_if.sv
// Requester-side bundle of the UART TX arbiter: per-requester byte valid,
// end-of-packet flag and byte, plus the arbiter's accept, grant and owner.
// Handshake: a byte from requester i moves when req[i] and ack[i] are both
// high in the same cycle; ack is only ever raised for the current owner.
interface uart_tx_arb_if #(
    parameter int D_W   = 8,
    parameter int N_REQ = 4
);
    localparam int OWN_W = $clog2(N_REQ);

    logic [N_REQ-1:0]     req;
    logic [N_REQ-1:0]     last;
    logic [N_REQ*D_W-1:0] data;
    logic [N_REQ-1:0]     ack;
    logic [N_REQ-1:0]     gnt;
    logic [OWN_W-1:0]     owner;

    // Requesters drive bytes and observe the arbiter's decisions.
    modport master (
        output req, last, data,
        input  ack, gnt, owner
    );

    // The arbiter observes the requesters and drives accept/grant/owner.
    modport slave (
        input  req, last, data,
        output ack, gnt, owner
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding a single UART TX FIFO. A requester is
// granted for a whole packet (locked until its last byte is accepted) and
// is dropped with an abort pulse if it stays silent for 2^TMO_W-1 cycles.
module uart_tx_arb #(
    parameter int D_W   = 8,
    parameter int N_REQ = 4,
    parameter int TMO_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arb_if.slave       bus,
    input  logic               fifo_tx_full,
    output logic               fifo_tx_wr_en,
    output logic [D_W-1:0]     fifo_tx_data_in,
    output logic               busy,
    output logic               abort
);
    localparam int OWN_W = $clog2(N_REQ);
    // Counter value one below the timeout limit: the next silent cycle aborts.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state, state_nxt;
    logic [OWN_W-1:0] owner_q, owner_nxt;
    logic [OWN_W-1:0] rr_ptr, rr_nxt;
    logic [OWN_W-1:0] owner_inc;
    logic [OWN_W-1:0] pick;
    logic [OWN_W:0]   cand;
    logic             found;
    logic [N_REQ-1:0] gnt_q, gnt_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             abort_q, abort_nxt;
    logic             accept;

    // Accept is gated by rst so nothing is written or acked during reset.
    assign accept    = rst & (state == XFER) & bus.req[owner_q] & ~fifo_tx_full;
    assign owner_inc = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + OWN_W'(1);

    assign bus.ack         = accept ? gnt_q : '0;
    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign fifo_tx_wr_en   = accept;
    assign fifo_tx_data_in = (state == XFER) ? bus.data[owner_q*D_W +: D_W] : '0;
    assign busy            = (state == XFER);
    assign abort           = abort_q;

    // Round-robin search: first requesting index at or above rr_ptr, wrapping.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (OWN_W+1)'(i);
            if (cand >= (OWN_W+1)'(N_REQ)) begin
                cand = cand - (OWN_W+1)'(N_REQ);
            end
            if (!found && bus.req[cand[OWN_W-1:0]]) begin
                pick  = cand[OWN_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Next-state logic: grant in IDLE, packet lock, end-of-packet and timeout in XFER.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        gnt_nxt   = gnt_q;
        rr_nxt    = rr_ptr;
        tmo_nxt   = tmo_cnt;
        abort_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = XFER;
                    owner_nxt = pick;
                    gnt_nxt   = N_REQ'(1) << pick;
                    tmo_nxt   = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    tmo_nxt = '0;
                    if (bus.last[owner_q]) begin
                        state_nxt = IDLE;
                        owner_nxt = '0;
                        gnt_nxt   = '0;
                        rr_nxt    = owner_inc;
                    end
                end else if (!bus.req[owner_q]) begin
                    // A full FIFO with req high is a stall and never counts here.
                    if (tmo_cnt == TMO_LAST) begin
                        abort_nxt = 1'b1;
                        state_nxt = IDLE;
                        owner_nxt = '0;
                        gnt_nxt   = '0;
                        rr_nxt    = owner_inc;
                        tmo_nxt   = '0;
                    end else begin
                        tmo_nxt = tmo_cnt + TMO_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant, owner, round-robin pointer, timeout counter and abort pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q <= '0;
            gnt_q   <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
            abort_q <= 1'b0;
        end else begin
            owner_q <= owner_nxt;
            gnt_q   <= gnt_nxt;
            rr_ptr  <= rr_nxt;
            tmo_cnt <= tmo_nxt;
            abort_q <= abort_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed packet scenarios followed by randomized
// traffic, every cycle compared against a packet-level reference model.
module tb_uart_tx_arb;
    localparam int D_W     = 8;
    localparam int N_REQ   = 4;
    localparam int TMO_W   = 4;
    localparam int TMO_MAX = (1 << TMO_W) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           fifo_tx_full;
    logic           fifo_tx_wr_en;
    logic [D_W-1:0] fifo_tx_data_in;
    logic           busy;
    logic           abort;

    uart_tx_arb_if #(.D_W(D_W), .N_REQ(N_REQ)) bus ();

    uart_tx_arb #(.D_W(D_W), .N_REQ(N_REQ), .TMO_W(TMO_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .fifo_tx_full    (fifo_tx_full),
        .fifo_tx_wr_en   (fifo_tx_wr_en),
        .fifo_tx_data_in (fifo_tx_data_in),
        .busy            (busy),
        .abort           (abort)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    int n_vec     = 0;
    int n_err     = 0;
    bit chk_en    = 1'b0;
    int cyc       = 0;
    int abort_cyc = -1;
    logic [D_W-1:0] exp_q[$];
    int got_q[$];
    int got_cyc[$];

    // Reference model: owner (-1 when idle), round-robin start, silent-cycle count.
    int m_own   = -1;
    int m_rr    = 0;
    int m_tmo   = 0;
    bit m_abort = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then the model advances one clock.
    always @(negedge clk) begin : mdl
        bit          acc;
        logic [31:0] e_gnt;
        int          c;
        if (chk_en) begin
            cyc++;
            acc   = rst && (m_own >= 0) && bus.req[m_own] && !fifo_tx_full;
            e_gnt = (m_own >= 0) ? (32'd1 << m_own) : 32'd0;
            check("gnt",     32'(bus.gnt),       e_gnt);
            check("owner",   32'(bus.owner),     (m_own >= 0) ? 32'(m_own) : 32'd0);
            check("busy",    32'(busy),          32'(m_own >= 0));
            check("ack",     32'(bus.ack),       acc ? e_gnt : 32'd0);
            check("wr_en",   32'(fifo_tx_wr_en), 32'(acc));
            check("data_in", 32'(fifo_tx_data_in),
                  (m_own >= 0) ? 32'(bus.data[m_own*D_W +: D_W]) : 32'd0);
            check("abort",   32'(abort),         32'(m_abort));
            if (abort) abort_cyc = cyc;

            if (acc) exp_q.push_back(bus.data[m_own*D_W +: D_W]);
            if (fifo_tx_wr_en) begin
                check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("sb_byte", 32'(fifo_tx_data_in), 32'(exp_q.pop_front()));
            end

            if (!rst) begin
                m_own   = -1;
                m_rr    = 0;
                m_tmo   = 0;
                m_abort = 1'b0;
            end else begin
                m_abort = 1'b0;
                if (m_own < 0) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        c = (m_rr + k) % N_REQ;
                        if (m_own < 0 && bus.req[c]) begin
                            m_own = c;
                            m_tmo = 0;
                        end
                    end
                end else if (acc) begin
                    m_tmo = 0;
                    if (bus.last[m_own]) begin
                        m_rr  = (m_own + 1) % N_REQ;
                        m_own = -1;
                    end
                end else if (!bus.req[m_own]) begin
                    m_tmo++;
                    if (m_tmo == TMO_MAX) begin
                        m_abort = 1'b1;
                        m_rr    = (m_own + 1) % N_REQ;
                        m_own   = -1;
                        m_tmo   = 0;
                    end
                end
            end
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req      = '0;
        bus.last     = '0;
        bus.data     = '0;
        fifo_tx_full = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Holds req[r] until ack[r] is seen; returns just after the accepting edge.
    task automatic wait_ack(input int r);
        bit a = 1'b0;
        int g = 0;
        while (!a && g < 100) begin
            @(negedge clk);
            a = bus.ack[r];
            tick();
            g++;
        end
        check("ack_seen", 32'(a), 32'd1);
    endtask

    task automatic send_packet(input int r, input int nbytes, input logic [D_W-1:0] b0);
        int k = 0;
        int g = 0;
        bit a;
        bus.req[r] = 1'b1;
        while (k < nbytes && g < 200) begin
            bus.data[r*D_W +: D_W] = D_W'(int'(b0) + k);
            bus.last[r]            = (k == nbytes - 1);
            @(negedge clk);
            a = bus.ack[r];
            tick();
            g++;
            if (a) k++;
        end
        check("pkt_done", 32'(k), 32'(nbytes));
        bus.req[r]  = 1'b0;
        bus.last[r] = 1'b0;
    endtask

    // Every masked requester streams 1-byte packets; records who is accepted and when.
    task automatic run_grants(input logic [N_REQ-1:0] mask, input int n);
        int g = 0;
        got_q.delete();
        got_cyc.delete();
        bus.req  = mask;
        bus.last = mask;
        for (int r = 0; r < N_REQ; r++) bus.data[r*D_W +: D_W] = D_W'(8'h50 + r);
        while (got_q.size() < n && g < 20 * n) begin
            @(negedge clk);
            for (int r = 0; r < N_REQ; r++) begin
                if (bus.ack[r]) begin
                    got_q.push_back(r);
                    got_cyc.push_back(cyc + 1);
                end
            end
            tick();
            g++;
        end
        check("grant_count", 32'(got_q.size()), 32'(n));
        bus.req  = '0;
        bus.last = '0;
    endtask

    initial begin
        int drop_cyc;
        int nwr;
        int nab;
        int g;
        logic [31:0] exp_order[5];

        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        rst = 1'b1;

        // Single 3-byte packet from requester 2, then round-robin resumes at 3.
        send_packet(2, 3, 8'h41);
        run_grants(4'b1001, 2);
        check("rr_after_pkt0", 32'(got_q[0]), 32'd3);
        check("rr_after_pkt1", 32'(got_q[1]), 32'd0);
        repeat (3) tick();

        // All four requesting from reset: order 0,1,2,3,0, one idle cycle apart.
        do_reset();
        run_grants(4'b1111, 5);
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check("rr_order", 32'(got_q[i]), exp_order[i]);
        for (int i = 1; i < 5; i++) check("rr_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd2);
        repeat (3) tick();

        // Backpressure on owner 1 mid-packet: ten full cycles, then 0x7E goes out.
        do_reset();
        bus.req[1] = 1'b1;
        bus.data[1*D_W +: D_W] = 8'h10;
        wait_ack(1);
        fifo_tx_full = 1'b1;
        bus.data[1*D_W +: D_W] = 8'h7E;
        bus.last[1] = 1'b1;
        nwr = 0;
        nab = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nwr += int'(fifo_tx_wr_en) + int'(bus.ack[1]);
            nab += int'(abort);
            tick();
        end
        check("bp_no_write", 32'(nwr), 32'd0);
        check("bp_no_abort", 32'(nab), 32'd0);
        fifo_tx_full = 1'b0;
        @(negedge clk);
        check("bp_release_wr", 32'(fifo_tx_wr_en), 32'd1);
        check("bp_release_data", 32'(fifo_tx_data_in), 32'h7E);
        tick();
        idle_inputs();
        repeat (2) tick();

        // Timeout: owner 0 goes silent after one byte; requester 1 is next.
        do_reset();
        bus.req = 4'b0011;
        bus.data[0*D_W +: D_W] = 8'h20;
        bus.data[1*D_W +: D_W] = 8'h21;
        bus.last[1] = 1'b1;
        wait_ack(0);
        bus.req[0] = 1'b0;
        drop_cyc   = cyc + 1;
        abort_cyc  = -1;
        g = 0;
        while (abort_cyc < 0 && g < 40) begin
            tick();
            g++;
        end
        check("tmo_latency", 32'(abort_cyc - drop_cyc), 32'd15);
        wait_ack(1);
        idle_inputs();
        tick();

        // Packet lock: owner 3 pauses while requester 0 waits.
        bus.req[3] = 1'b1;
        bus.data[3*D_W +: D_W] = 8'h30;
        wait_ack(3);
        bus.req[3] = 1'b0;
        bus.req[0] = 1'b1;
        bus.last[0] = 1'b1;
        bus.data[0*D_W +: D_W] = 8'h31;
        nab = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nab += int'(bus.ack[0]);
            check("lock_gnt", 32'(bus.gnt), 32'b1000);
            tick();
        end
        check("lock_no_ack0", 32'(nab), 32'd0);
        bus.req[3]  = 1'b1;
        bus.last[3] = 1'b1;
        bus.data[3*D_W +: D_W] = 8'h32;
        wait_ack(3);
        bus.req[3] = 1'b0;
        wait_ack(0);
        idle_inputs();
        tick();

        // Reset in the middle of a packet from requester 2.
        bus.req[2] = 1'b1;
        bus.data[2*D_W +: D_W] = 8'h60;
        wait_ack(2);
        bus.data[2*D_W +: D_W] = 8'h61;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.req  = 4'b0110;
        bus.last = 4'b0110;
        bus.data[1*D_W +: D_W] = 8'h62;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        check("rst_regrant", 32'(bus.gnt), 32'b0010);
        tick();
        idle_inputs();
        repeat (3) tick();

        // Randomized traffic, including quiet stretches that provoke timeouts.
        for (int c = 0; c < 3000; c++) begin
            int p;
            p = ((c % 400) < 60) ? 5 : 70;
            for (int r = 0; r < N_REQ; r++) begin
                bus.req[r]  = ($urandom_range(0, 99) < p);
                bus.last[r] = ($urandom_range(0, 3) == 0);
                bus.data[r*D_W +: D_W] = D_W'($urandom_range(0, 255));
            end
            fifo_tx_full = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 499) != 0);
            tick();
        end

        idle_inputs();
        rst = 1'b1;
        repeat (40) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter D_W, default 8: data byte width in bits.
REQ-002 Parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-003 Parameter TMO_W, default 8: width of the abort timeout counter.
REQ-004 Local constant OWN_W SHALL equal clog2(N_REQ).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 req  in  N_REQ  per-requester byte-valid.
REQ-008 last  in  N_REQ  per-requester end-of-packet flag, qualified by req.
REQ-009 data  in  N_REQ*D_W  per-requester byte; requester i uses bits [i*D_W +: D_W].
REQ-010 ack  out  N_REQ  byte accepted from requester i this cycle.
REQ-011 gnt  out  N_REQ  registered one-hot grant; all zero when idle.
REQ-012 owner  out  OWN_W  index of the granted requester; 0 when idle.
REQ-013 fifo_tx_full  in  1  TX FIFO cannot accept a write.
REQ-014 fifo_tx_wr_en  out  1  TX FIFO write strobe.
REQ-015 fifo_tx_data_in  out  D_W  TX FIFO write data.
REQ-016 busy  out  1  high while in XFER.
REQ-017 abort  out  1  one-cycle pulse when a packet is dropped on timeout.

Function
REQ-018 FSM SHALL have two states, IDLE and XFER.
REQ-019 IDLE: when req is nonzero, select the first requester with req high, searching upward from rr_ptr with wrap from N_REQ-1 to 0; register it in owner, set gnt[owner], go to XFER.
REQ-020 IDLE SHALL assert no ack and no fifo_tx_wr_en; first accept is earliest one cycle after req is sampled.
REQ-021 XFER accept = req[owner] & ~fifo_tx_full; ack[owner] = fifo_tx_wr_en = accept, combinational, same cycle.
REQ-022 fifo_tx_data_in SHALL equal data slice of owner in XFER and 0 in IDLE.
REQ-023 ack bits of non-owners SHALL be 0 at all times.
REQ-024 accept & last[owner]: go to IDLE next cycle; rr_ptr <= owner+1, wrapping to 0 after N_REQ-1; gnt <= 0.
REQ-025 Packet lock: XFER SHALL hold the owner while req[owner] is low and last has not been accepted; other requests are ignored until IDLE.
REQ-026 fifo_tx_full SHALL stall without counting toward timeout.
REQ-027 Timeout counter SHALL clear on entry to XFER and on every accept.
REQ-028 Timeout counter SHALL increment on each XFER cycle with req[owner] low.
REQ-029 When the timeout counter reaches 2^TMO_W-1: pulse abort, go to IDLE, advance rr_ptr as in REQ-024.
REQ-030 At least one IDLE cycle SHALL separate consecutive packets.
REQ-031 busy SHALL equal (state==XFER).

Reset
REQ-032 rst low at a clock edge SHALL force the following, regardless of state (including mid-packet): state IDLE, rr_ptr 0, owner 0, gnt 0, timeout counter 0, abort 0.
REQ-033 Outputs SHALL be 0 during reset: fifo_tx_wr_en 0 and ack 0 in every cycle rst is low.
REQ-034 The first arbitration after reset release SHALL start from requester 0.

Verification
REQ-035 Single packet: req[2]=1 with bytes 0x41,0x42,0x43, last on 0x43 -> gnt=4'b0100 one cycle later; three fifo_tx_wr_en pulses carrying 0x41,0x42,0x43; then IDLE; rr_ptr=3.
REQ-036 Round-robin: req=4'b1111, each requester sends a 1-byte packet -> grant order 0,1,2,3,0; each grant separated by exactly one IDLE cycle.
REQ-037 Backpressure: owner 1 mid-packet, fifo_tx_full=1 for 10 cycles -> no wr_en, no ack, no abort; byte 0x7E written on the first cycle full drops.
REQ-038 Timeout: owner 0 drops req after one non-last byte, TMO_W=4 -> abort pulse 15 cycles later; gnt 0; next grant goes to requester 1 if requesting.
REQ-039 Lock: owner 3 idle mid-packet while req[0]=1 -> requester 0 receives no ack and gnt stays 4'b1000 until last from requester 3 is accepted.
REQ-040 Reset mid-packet: rst low during XFER of owner 2 -> next cycle busy=0, gnt=0, no wr_en; after release with req=4'b0110, requester 1 is granted.
